// File: rtl/mem_issue_queue_pkg.sv
// mem_issue_queue_pkg: FSM encoding, queue entry layout and the bhw codes
// shared between the issue queue and FU_mem.
package mem_issue_queue_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_DRAIN = 3'd4
  } mq_state_e;

  // Width/sign codes understood by FU_mem; the queue never interprets them.
  localparam logic [2:0] BHW_B  = 3'b000;
  localparam logic [2:0] BHW_H  = 3'b001;
  localparam logic [2:0] BHW_W  = 3'b010;
  localparam logic [2:0] BHW_BU = 3'b100;
  localparam logic [2:0] BHW_HU = 3'b101;

  // Operand part of a queue entry; the tag is appended below it by the top.
  typedef struct packed {
    logic        mem_w;
    logic [2:0]  bhw;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
  } mem_op_t;

  localparam int OP_W = $bits(mem_op_t);

endpackage

// File: rtl/mem_issue_queue_fifo.sv
// mem_issue_queue_fifo: synchronous FIFO with occupancy count, a flush that
// empties it in one cycle, and a peek at the entry behind the head so the
// issue logic can launch the next op in the same cycle the head retires.
module mem_issue_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_head,
  output logic [WIDTH-1:0]         o_next,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_rd_ptr_p1;

  assign w_rd_ptr_p1 = r_rd_ptr + PTR_W'(1);
  assign o_head      = r_mem[r_rd_ptr];
  assign o_next      = r_mem[w_rd_ptr_p1];
  assign o_count     = r_count;

  // Storage array; written at the tail, contents need no reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_rd_en) begin
        r_rd_ptr <= w_rd_ptr_p1;
      end
      case ({i_wr_en, i_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_issue_queue.sv
// mem_issue_queue: in-order issue buffer in front of FU_mem. Launches one op
// at a time with a one-cycle EN pulse, times the fixed FU latency, and
// presents the result on a valid/ready writeback port.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic                   enq_mem_w,
  input  logic [2:0]             enq_bhw,
  input  logic [31:0]            enq_rs1_data,
  input  logic [31:0]            enq_rs2_data,
  input  logic [31:0]            enq_imm,
  input  logic [TAG_W-1:0]       enq_tag,
  output logic                   fu_en,
  output logic                   fu_mem_w,
  output logic [2:0]             fu_bhw,
  output logic [31:0]            fu_rs1_data,
  output logic [31:0]            fu_rs2_data,
  output logic [31:0]            fu_imm,
  input  logic [31:0]            fu_mem_data,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [TAG_W-1:0]       wb_tag,
  output logic                   wb_is_store,
  output logic [31:0]            wb_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int ENT_W   = OP_W + TAG_W;
  localparam int COUNT_W = $clog2(DEPTH) + 1;
  localparam int CNT_W   = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  mq_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fu_en;
  mem_op_t          r_fu_op;
  logic [TAG_W-1:0] r_fu_tag;
  logic             r_wb_valid;
  logic [TAG_W-1:0] r_wb_tag;
  logic             r_wb_is_store;
  logic [31:0]      r_wb_data;

  mem_op_t          w_enq_op;
  logic [ENT_W-1:0] w_enq_entry;
  logic [ENT_W-1:0] w_head_entry;
  logic [ENT_W-1:0] w_next_entry;
  logic [ENT_W-1:0] w_load_entry;
  mem_op_t          w_load_op;
  logic [TAG_W-1:0] w_load_tag;
  logic             w_full;
  logic             w_enq;
  logic             w_deq;
  logic             w_more;

  assign w_enq_op    = '{mem_w: enq_mem_w, bhw: enq_bhw, rs1: enq_rs1_data,
                         rs2: enq_rs2_data, imm: enq_imm};
  assign w_enq_entry = {w_enq_op, enq_tag};

  // enq_ready looks only at the registered count, so a full queue refuses an
  // offer even in the cycle its head retires.
  assign w_full    = (count == COUNT_W'(DEPTH));
  assign enq_ready = rst_n & ~w_full;
  assign w_enq     = enq_valid & enq_ready & ~flush;
  assign w_deq     = r_wb_valid & wb_ready;
  // Something is left to issue once the retiring head is gone.
  assign w_more    = (count > COUNT_W'(1)) | w_enq;

  mem_issue_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (flush),
    .i_wr_en   (w_enq),
    .i_wr_data (w_enq_entry),
    .i_rd_en   (w_deq),
    .o_head    (w_head_entry),
    .o_next    (w_next_entry),
    .o_count   (count)
  );

  // Select the entry that becomes the head on the edge we enter ISSUE: on a
  // WB retire that is the second entry, or the one being enqueued right now.
  always_comb begin
    w_load_entry = w_head_entry;
    if (r_state == ST_WB) begin
      if (count > COUNT_W'(1)) begin
        w_load_entry = w_next_entry;
      end else begin
        w_load_entry = w_enq_entry;
      end
    end else begin
      w_load_entry = w_head_entry;
    end
  end

  assign w_load_op  = mem_op_t'(w_load_entry[ENT_W-1:TAG_W]);
  assign w_load_tag = w_load_entry[TAG_W-1:0];

  // Issue sequencing, latency timing and writeback capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_fu_en       <= 1'b0;
      r_fu_op       <= '0;
      r_fu_tag      <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_tag      <= '0;
      r_wb_is_store <= 1'b0;
      r_wb_data     <= 32'd0;
    end else begin
      r_fu_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!flush && (count != '0)) begin
            r_state  <= ST_ISSUE;
            r_fu_en  <= 1'b1;
            r_fu_op  <= w_load_op;
            r_fu_tag <= w_load_tag;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= CNT_W'(LATENCY);
          r_state <= flush ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_cnt <= '0;
            if (flush) begin
              r_state <= ST_IDLE;
            end else begin
              r_state       <= ST_WB;
              r_wb_valid    <= 1'b1;
              r_wb_tag      <= r_fu_tag;
              r_wb_is_store <= r_fu_op.mem_w;
              r_wb_data     <= r_fu_op.mem_w ? 32'd0 : fu_mem_data;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (flush) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // A squashed op still occupies FU_mem until its latency expires.
          if (r_cnt <= CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_WB: begin
          if (flush) begin
            r_wb_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (wb_ready) begin
            r_wb_valid <= 1'b0;
            if (w_more) begin
              r_state  <= ST_ISSUE;
              r_fu_en  <= 1'b1;
              r_fu_op  <= w_load_op;
              r_fu_tag <= w_load_tag;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fu_en       = r_fu_en;
  assign fu_mem_w    = r_fu_op.mem_w;
  assign fu_bhw      = r_fu_op.bhw;
  assign fu_rs1_data = r_fu_op.rs1;
  assign fu_rs2_data = r_fu_op.rs2;
  assign fu_imm      = r_fu_op.imm;
  assign wb_valid    = r_wb_valid;
  assign wb_tag      = r_wb_tag;
  assign wb_is_store = r_wb_is_store;
  assign wb_data     = r_wb_data;

endmodule

// File: tb/tb_mem_issue_queue.sv
// tb_mem_issue_queue: directed scenario tests for mem_issue_queue with
// DEPTH=4, TAG_W=4, LATENCY=2.
module tb_mem_issue_queue;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int LATENCY = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             enq_valid = 1'b0;
  logic             enq_ready;
  logic             enq_mem_w = 1'b0;
  logic [2:0]       enq_bhw = 3'b010;
  logic [31:0]      enq_rs1_data = 32'd0;
  logic [31:0]      enq_rs2_data = 32'd0;
  logic [31:0]      enq_imm = 32'd0;
  logic [TAG_W-1:0] enq_tag = 4'd0;
  logic             fu_en;
  logic             fu_mem_w;
  logic [2:0]       fu_bhw;
  logic [31:0]      fu_rs1_data;
  logic [31:0]      fu_rs2_data;
  logic [31:0]      fu_imm;
  logic [31:0]      fu_mem_data = 32'd0;
  logic             wb_valid;
  logic             wb_ready = 1'b0;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_is_store;
  logic [31:0]      wb_data;
  logic [2:0]       count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_mem_w(enq_mem_w),
    .enq_bhw(enq_bhw), .enq_rs1_data(enq_rs1_data), .enq_rs2_data(enq_rs2_data),
    .enq_imm(enq_imm), .enq_tag(enq_tag),
    .fu_en(fu_en), .fu_mem_w(fu_mem_w), .fu_bhw(fu_bhw), .fu_rs1_data(fu_rs1_data),
    .fu_rs2_data(fu_rs2_data), .fu_imm(fu_imm), .fu_mem_data(fu_mem_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
    .wb_is_store(wb_is_store), .wb_data(wb_data), .count(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic w, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [3:0] tag);
    enq_valid    = 1'b1;
    enq_mem_w    = w;
    enq_bhw      = 3'b010;
    enq_rs1_data = rs1;
    enq_rs2_data = rs2;
    enq_imm      = imm;
    enq_tag      = tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); end
    total++; if (fu_en !== 1'b0) begin bad++; $display("FAIL rst_fu_en got=%b exp=0", fu_en); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL rst_enq_ready_in_reset got=%b exp=0", enq_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL rst_enq_ready got=%b exp=1", enq_ready); end
    total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL rst_wb_data got=%h exp=0", wb_data); end
  endtask

  task automatic test_single_load();
    fu_mem_data = 32'hDEAD_BEEF;
    offer(1'b0, 32'h100, 32'h0, 32'h4, 4'd3);
    tick();  // E0
    enq_valid = 1'b0;
    total++; if (count !== 3'd1) begin bad++; $display("FAIL sl_count got=%0d exp=1", count); end
    total++; if (fu_en !== 1'b0) begin bad++; $display("FAIL sl_fu_en_e0 got=%b exp=0", fu_en); end
    tick();  // E1
    total++; if (fu_en !== 1'b1) begin bad++; $display("FAIL sl_fu_en_e1 got=%b exp=1", fu_en); end
    total++; if (fu_rs1_data !== 32'h100 || fu_imm !== 32'h4 || fu_mem_w !== 1'b0)
      begin bad++; $display("FAIL sl_fu_ops got=%h/%h/%b exp=100/4/0", fu_rs1_data, fu_imm, fu_mem_w); end
    tick();  // E2
    total++; if (fu_en !== 1'b0) begin bad++; $display("FAIL sl_fu_en_e2 got=%b exp=0", fu_en); end
    tick();  // E3
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL sl_wb_valid_e3 got=%b exp=0", wb_valid); end
    tick();  // E4
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL sl_wb_valid_e4 got=%b exp=1", wb_valid); end
    total++; if (wb_tag !== 4'd3 || wb_data !== 32'hDEAD_BEEF || wb_is_store !== 1'b0)
      begin bad++; $display("FAIL sl_wb got=%0d/%h/%b exp=3/deadbeef/0", wb_tag, wb_data, wb_is_store); end
    wb_ready = 1'b1;
    tick();  // E5 handshake
    wb_ready = 1'b0;
    total++; if (wb_valid !== 1'b0 || count !== 3'd0)
      begin bad++; $display("FAIL sl_retire got=%b/%0d exp=0/0", wb_valid, count); end
  endtask

  task automatic test_back_to_back();
    int          fu_cyc[$];
    logic [3:0]  tags[$];
    logic [31:0] datas[$];
    logic        sts[$];
    int          exp_cyc[3]  = '{1, 5, 9};
    logic [3:0]  exp_tag[3]  = '{4'd5, 4'd6, 4'd7};
    logic [31:0] exp_data[3] = '{32'h1234_5678, 32'd0, 32'h1234_5678};
    logic        exp_st[3]   = '{1'b0, 1'b1, 1'b0};
    wb_ready    = 1'b1;
    fu_mem_data = 32'h1234_5678;
    for (int c = 0; c < 20; c++) begin
      if (c == 0) offer(1'b0, 32'h200, 32'h0, 32'h8, 4'd5);
      else if (c == 1) offer(1'b1, 32'h300, 32'hCAFE, 32'h0, 4'd6);
      else if (c == 2) offer(1'b0, 32'h400, 32'h0, 32'hC, 4'd7);
      else enq_valid = 1'b0;
      tick();
      if (c == 2) begin
        total++; if (count !== 3'd3) begin bad++; $display("FAIL b2b_count3 got=%0d exp=3", count); end
      end
      if (fu_en === 1'b1) begin
        fu_cyc.push_back(c);
        if (c == 5) begin
          total++; if (fu_rs2_data !== 32'hCAFE || fu_mem_w !== 1'b1)
            begin bad++; $display("FAIL b2b_store_ops got=%h/%b exp=cafe/1", fu_rs2_data, fu_mem_w); end
        end
      end
      if (wb_valid === 1'b1) begin
        tags.push_back(wb_tag);
        datas.push_back(wb_data);
        sts.push_back(wb_is_store);
      end
    end
    wb_ready = 1'b0;
    total++;
    if (fu_cyc.size() != 3 || tags.size() != 3) begin
      bad++; $display("FAIL b2b_sizes got=%0d/%0d exp=3/3", fu_cyc.size(), tags.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (fu_cyc[i] != exp_cyc[i] || tags[i] !== exp_tag[i] || datas[i] !== exp_data[i] || sts[i] !== exp_st[i]) begin
          bad++;
          $display("FAIL b2b_op%0d got=cyc%0d/tag%0d/%h/%b exp=cyc%0d/tag%0d/%h/%b", i, fu_cyc[i], tags[i],
                   datas[i], sts[i], exp_cyc[i], exp_tag[i], exp_data[i], exp_st[i]);
          break;
        end
      end
    end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_count0 got=%0d exp=0", count); end
  endtask

  task automatic test_full();
    logic [3:0] tags[$];
    int         budget;
    fu_mem_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      offer(1'b0, 32'h500 + i, 32'h0, 32'h0, 4'(8 + i));
      tick();
    end
    total++; if (count !== 3'd4 || enq_ready !== 1'b0)
      begin bad++; $display("FAIL full_state got=%0d/%b exp=4/0", count, enq_ready); end
    offer(1'b0, 32'h600, 32'h0, 32'h0, 4'd12);
    tick();  // 5th offered while full; head now in WB
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_reject got=%0d exp=4", count); end
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL full_wb_valid got=%b exp=1", wb_valid); end
    wb_ready = 1'b1;
    tick();  // retire with 5th still offered; must not enter
    wb_ready = 1'b0;
    total++; if (count !== 3'd3 || enq_ready !== 1'b1)
      begin bad++; $display("FAIL full_deq got=%0d/%b exp=3/1", count, enq_ready); end
    tick();  // 5th accepted now
    enq_valid = 1'b0;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_refill got=%0d exp=4", count); end
    wb_ready = 1'b1;
    budget = 0;
    while (count !== 3'd0 && budget < 60) begin
      tick();
      budget++;
      if (wb_valid === 1'b1) tags.push_back(wb_tag);
    end
    wb_ready = 1'b0;
    total++;
    if (tags.size() != 4) begin
      bad++; $display("FAIL full_drain_count got=%0d exp=4", tags.size());
    end else if (tags[0] !== 4'd9 || tags[1] !== 4'd10 || tags[2] !== 4'd11 || tags[3] !== 4'd12) begin
      bad++; $display("FAIL full_order got=%0d,%0d,%0d,%0d exp=9,10,11,12", tags[0], tags[1], tags[2], tags[3]);
    end
  endtask

  task automatic test_backpressure();
    int budget;
    logic [3:0]  hold_tag;
    logic [31:0] hold_data;
    fu_mem_data = 32'hAAAA_5555;
    offer(1'b0, 32'h700, 32'h0, 32'h0, 4'd1);
    tick();
    offer(1'b0, 32'h704, 32'h0, 32'h0, 4'd2);
    tick();
    enq_valid = 1'b0;
    budget = 0;
    while (wb_valid !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL bp_wait got=%b exp=1", wb_valid); end
    hold_tag  = 4'd1;
    hold_data = 32'hAAAA_5555;
    fu_mem_data = 32'h0BAD_0BAD;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (wb_valid !== 1'b1 || wb_tag !== hold_tag || wb_data !== hold_data || fu_en !== 1'b0 || count !== 3'd2) begin
        bad++;
        $display("FAIL bp_hold c=%0d got=%b/%0d/%h/%b/%0d exp=1/1/aaaa5555/0/2", c, wb_valid, wb_tag, wb_data, fu_en, count);
      end
    end
    wb_ready = 1'b1;
    budget = 0;
    while (count !== 3'd0 && budget < 20) begin
      tick();
      budget++;
    end
    wb_ready = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL bp_drain got=%0d exp=0", count); end
  endtask

  task automatic test_flush_wait();
    fu_mem_data = 32'h1111_2222;
    offer(1'b0, 32'h800, 32'h0, 32'h0, 4'd4);
    tick();  // E0
    offer(1'b1, 32'h804, 32'h55, 32'h0, 4'd5);
    tick();  // E1 head issued
    offer(1'b0, 32'h808, 32'h0, 32'h0, 4'd6);
    tick();  // E2 head in WAIT, count=3
    total++; if (count !== 3'd3) begin bad++; $display("FAIL fl_pre_count got=%0d exp=3", count); end
    flush = 1'b1;
    offer(1'b0, 32'h80C, 32'h0, 32'h0, 4'd7);  // ignored in flush cycle
    tick();  // E3
    flush = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL fl_count got=%0d exp=0", count); end
    offer(1'b0, 32'h900, 32'h0, 32'h10, 4'd13);
    tick();  // E4: drain expires, new entry lands
    enq_valid = 1'b0;
    total++; if (wb_valid !== 1'b0 || fu_en !== 1'b0 || count !== 3'd1)
      begin bad++; $display("FAIL fl_drain got=%b/%b/%0d exp=0/0/1", wb_valid, fu_en, count); end
    tick();  // E5
    total++; if (fu_en !== 1'b1 || fu_rs1_data !== 32'h900)
      begin bad++; $display("FAIL fl_reissue got=%b/%h exp=1/900", fu_en, fu_rs1_data); end
    tick();
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL fl_no_wb got=%b exp=0", wb_valid); end
    tick();  // E8
    total++; if (wb_valid !== 1'b1 || wb_tag !== 4'd13 || wb_data !== 32'h1111_2222)
      begin bad++; $display("FAIL fl_new_wb got=%b/%0d/%h exp=1/13/11112222", wb_valid, wb_tag, wb_data); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL fl_end got=%0d exp=0", count); end
  endtask

  task automatic test_async_reset();
    offer(1'b0, 32'hA00, 32'h0, 32'h0, 4'd2);
    tick();
    offer(1'b0, 32'hA04, 32'h0, 32'h0, 4'd4);
    tick();
    enq_valid = 1'b0;
    tick();  // head in WAIT
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (wb_valid !== 1'b0 || fu_en !== 1'b0 || count !== 3'd0 || fu_rs1_data !== 32'd0)
      begin bad++; $display("FAIL ar_immediate got=%b/%b/%0d/%h exp=0/0/0/0", wb_valid, fu_en, count, fu_rs1_data); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    fu_mem_data = 32'h7777_8888;
    offer(1'b0, 32'hB00, 32'h0, 32'h4, 4'd9);
    tick();  // E0
    enq_valid = 1'b0;
    total++; if (count !== 3'd1 || fu_en !== 1'b0)
      begin bad++; $display("FAIL ar_e0 got=%0d/%b exp=1/0", count, fu_en); end
    tick();  // E1
    total++; if (fu_en !== 1'b1 || fu_rs1_data !== 32'hB00)
      begin bad++; $display("FAIL ar_e1 got=%b/%h exp=1/b00", fu_en, fu_rs1_data); end
    tick();
    tick();  // E3
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL ar_e3 got=%b exp=0", wb_valid); end
    tick();  // E4
    total++; if (wb_valid !== 1'b1 || wb_tag !== 4'd9 || wb_data !== 32'h7777_8888)
      begin bad++; $display("FAIL ar_e4 got=%b/%0d/%h exp=1/9/77778888", wb_valid, wb_tag, wb_data); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_back_to_back();
    test_full();
    test_backpressure();
    test_flush_wait();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_issue_queue.md
Name: mem_issue_queue

Overview:
- In-order issue buffer placed directly upstream of the memory functional unit (FU_mem).
- Accepts decoded load/store micro-ops whose operands are already resolved, holds them in a small FIFO, and launches one at a time to FU_mem with a one-cycle EN pulse.
- Times FU_mem's fixed latency, captures its result, and presents it to the writeback bus with a valid/ready handshake.
- Only one memory op is in flight at a time.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- TAG_W, 4, destination/ROB tag width
- LATENCY, 2, FU_mem cycles from EN pulse to valid mem_data (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  synchronous squash of queued and in-flight work
- enq_valid  in  1  new op offered
- enq_ready  out  1  queue can accept (count < DEPTH)
- enq_mem_w  in  1  1 = store, 0 = load
- enq_bhw  in  3  width/sign code, passed through unchanged
- enq_rs1_data  in  32  base address operand
- enq_rs2_data  in  32  store data
- enq_imm  in  32  address offset
- enq_tag  in  TAG_W  result tag
- fu_en  out  1  EN pulse to FU_mem
- fu_mem_w  out  1  to FU_mem
- fu_bhw  out  3  to FU_mem
- fu_rs1_data  out  32  to FU_mem
- fu_rs2_data  out  32  to FU_mem
- fu_imm  out  32  to FU_mem
- fu_mem_data  in  32  FU_mem result
- wb_valid  out  1  completion available
- wb_ready  in  1  writeback bus accepts
- wb_tag  out  TAG_W  tag of completing op
- wb_is_store  out  1  completion is a store (wb_data = 0)
- wb_data  out  32  load result
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- **Reset (rst_n = 0, asynchronous):**
  - State = IDLE; FIFO pointers and count = 0; counter = 0.
  - All outputs 0, except enq_ready = 1 once rst_n is high.
  - A reset mid-operation abandons any in-flight op; its FU_mem output is never sampled.
- **FIFO:**
  - Write on enq_valid && enq_ready.
  - Head entry is removed on the wb handshake (wb_valid && wb_ready), or by flush.
  - enq_ready is registered-count based, so a full queue takes no enqueue even when a dequeue happens in the same cycle.
  - Pointers wrap modulo DEPTH.
  - A simultaneous enq and deq keeps count unchanged.
- **FSM states:** IDLE, ISSUE, WAIT, WB, DRAIN.
- **IDLE:**
  - Goes to ISSUE at the next edge if count ≠ 0 (the registered value) and flush = 0.
- **ISSUE (exactly 1 cycle):**
  - fu_en = 1.
  - fu_* operand outputs are loaded from the head entry on entry to ISSUE and held stable until leaving WAIT/DRAIN.
  - Counter loads LATENCY; next state is WAIT.
- **WAIT:**
  - Counter decrements each cycle.
  - At the edge where counter == 1: wb_data <= fu_mem_w ? 0 : fu_mem_data; wb_tag and wb_is_store are taken from the head entry; next state is WB.
  - WAIT therefore lasts exactly LATENCY cycles.
- **WB:**
  - wb_valid = 1; wb_tag, wb_is_store, and wb_data are held stable until wb_ready.
  - On the handshake, the head is dequeued. Next state is ISSUE if count after the dequeue is ≠ 0 (back-to-back, no IDLE bubble); otherwise IDLE.
- **Timing:** an enqueue at edge E0 into an empty queue gives fu_en high in cycle [E1,E2) and wb_valid high from edge E(2+LATENCY).
- **Flush:**
  - All unissued entries are dropped; count goes to 0, including the head if it has not yet been issued.
  - enq is ignored in the flush cycle.
  - From ISSUE/WAIT the FSM goes to DRAIN: the counter keeps running to completion with no wb_valid, then IDLE. The entry is discarded.
  - From WB: wb_valid drops next cycle and the FSM goes to IDLE.
  - flush has priority over a simultaneous wb handshake: the handshake completes in that cycle, and everything else is dropped.
  - Stores already launched to FU_mem cannot be cancelled.
- **In-flight limit:** at most one op in flight; no other fu_en until the FSM returns to ISSUE.
- **Width rules:** bhw, addresses, and data are passed unmodified. No arithmetic beyond the counter and pointers.

Decomposition:
- **Shared package (e.g. mem_pkg):**
  - FSM state encoding (3-bit localparams IDLE, ISSUE, WAIT, WB, DRAIN).
  - The entry layout: {mem_w, bhw, rs1, rs2, imm, tag} = 1+3+96+TAG_W bits.
  - The bhw code constants shared with FU_mem.
- **Sub-module:** mem_op_fifo, a generic synchronous FIFO (parameters DEPTH and width) with count output.
- The FSM and latency counter stay in the top level.

Test Plan:
- **Single load, LATENCY=2:** enqueue a load (rs1=0x100, imm=4, tag=3) at cycle 0, FU_mem returns 0xDEADBEEF → fu_en high in cycle 1 only; wb_valid from cycle 4 with wb_tag=3 and wb_data=0xDEADBEEF.
- **Back-to-back ops with wb_ready tied 1:** enqueue 3 ops → three fu_en pulses spaced LATENCY+2 cycles apart, tags in order, count 3→0.
- **Full queue:** enqueue 4 ops while wb_ready=0 → count=4 and enq_ready=0. A 5th offer is not accepted. Asserting wb_ready → one dequeue, then enq_ready=1.
- **Backpressure:** hold wb_ready=0 for 10 cycles → wb_valid, wb_tag, and wb_data stay stable, and no new fu_en is issued.
- **Flush in WAIT:** flush with 3 entries queued and head in flight → count=0; no wb_valid for any of them; fu_en is not reasserted; the FSM returns to IDLE after the counter expires.
- **Async reset:** drop rst_n mid-WAIT, without a clock edge → wb_valid=0, fu_en=0, count=0 immediately. After release, a new enqueue follows the single-load timing.
